// File: rtl/nor_seq_pkg.sv
// ============================================================================
// Module   : nor_seq_pkg
// Brief    : Opcodes, FSM states, microcode field codes and step counts for
//            the sequential NOR-only logic unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package nor_seq_pkg;

  localparam logic [2:0] OP_NOR  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SRC_A  = 2'd0;
  localparam logic [1:0] SRC_B  = 2'd1;
  localparam logic [1:0] SRC_T0 = 2'd2;
  localparam logic [1:0] SRC_T1 = 2'd3;

  localparam logic [1:0] DST_T0  = 2'd0;
  localparam logic [1:0] DST_T1  = 2'd1;
  localparam logic [1:0] DST_RES = 2'd2;

  localparam logic [2:0] N_NOR  = 3'd1;
  localparam logic [2:0] N_OR   = 3'd2;
  localparam logic [2:0] N_NOT  = 3'd1;
  localparam logic [2:0] N_AND  = 3'd3;
  localparam logic [2:0] N_NAND = 3'd4;
  localparam logic [2:0] N_XOR  = 3'd5;
  localparam logic [2:0] N_XNOR = 3'd4;

  typedef struct packed {
    logic [1:0] srcx;
    logic [1:0] srcy;
    logic [1:0] dst;
    logic       last;
  } uc_t;

  function automatic uc_t uc_ent(input logic [1:0] sx, input logic [1:0] sy,
                                 input logic [1:0] d, input logic l);
    uc_t e;
    e.srcx = sx;
    e.srcy = sy;
    e.dst  = d;
    e.last = l;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nor_32bit.sv
// ============================================================================
// Module   : nor_32bit
// Brief    : 32-bit bitwise NOR gate shared by the sequential logic unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = ~(a | b);

endmodule

`default_nettype wire

// File: rtl/nor_seq_ucode.sv
// ============================================================================
// Module   : nor_seq_ucode
// Brief    : Combinational microcode ROM: (op, step) -> NOR sources,
//            destination and last-step flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nor_seq_ucode
  import nor_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] step,
  output uc_t        uc
);

  always_comb begin
    uc = uc_ent(SRC_A, SRC_A, DST_RES, 1'b1);
    case (op)
      OP_NOR: uc = uc_ent(SRC_A, SRC_B, DST_RES, 1'b1);
      OP_NOT: uc = uc_ent(SRC_A, SRC_A, DST_RES, 1'b1);
      OP_OR: begin
        case (step)
          3'd0:    uc = uc_ent(SRC_A,  SRC_B,  DST_T0,  1'b0);
          default: uc = uc_ent(SRC_T0, SRC_T0, DST_RES, 1'b1);
        endcase
      end
      OP_AND, OP_NAND: begin
        case (step)
          3'd0:    uc = uc_ent(SRC_A,  SRC_A,  DST_T0, 1'b0);
          3'd1:    uc = uc_ent(SRC_B,  SRC_B,  DST_T1, 1'b0);
          3'd2:    uc = (op == OP_AND) ? uc_ent(SRC_T0, SRC_T1, DST_RES, 1'b1)
                                       : uc_ent(SRC_T0, SRC_T1, DST_T0,  1'b0);
          default: uc = uc_ent(SRC_T0, SRC_T0, DST_RES, 1'b1);
        endcase
      end
      // XNOR leaves ~A&B in T1 and A&~B in T0 before the final NOR
      OP_XNOR, OP_XOR: begin
        case (step)
          3'd0:    uc = uc_ent(SRC_A,  SRC_B,  DST_T0, 1'b0);
          3'd1:    uc = uc_ent(SRC_A,  SRC_T0, DST_T1, 1'b0);
          3'd2:    uc = uc_ent(SRC_B,  SRC_T0, DST_T0, 1'b0);
          3'd3:    uc = (op == OP_XNOR) ? uc_ent(SRC_T1, SRC_T0, DST_RES, 1'b1)
                                        : uc_ent(SRC_T1, SRC_T0, DST_T0,  1'b0);
          default: uc = uc_ent(SRC_T0, SRC_T0, DST_RES, 1'b1);
        endcase
      end
      default: uc = uc_ent(SRC_A, SRC_A, DST_RES, 1'b1);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nor_seq_alu.sv
// ============================================================================
// Module   : nor_seq_alu
// Brief    : Multi-cycle logic unit building all logic ops from one NOR.
// Options  : NOR_SEQ_CYCLE_COUNT_EN adds the cycles[2:0] output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nor_seq_alu
  import nor_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef NOR_SEQ_CYCLE_COUNT_EN
  output logic [2:0]       cycles,
`endif
  output logic [WIDTH-1:0] result
);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [2:0]       r_step;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t0;
  logic [WIDTH-1:0] r_t1;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  uc_t              w_uc;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_nor;
  logic             w_accept;
  logic             w_ill;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_ill    = (op == OP_ILL);

  nor_seq_ucode u_ucode (
    .op   (r_op),
    .step (r_step),
    .uc   (w_uc)
  );

  nor_32bit u_nor (
    .a (w_x),
    .b (w_y),
    .y (w_nor)
  );

  always_comb begin
    w_x = r_a;
    w_y = r_a;
    case (w_uc.srcx)
      SRC_A:   w_x = r_a;
      SRC_B:   w_x = r_b;
      SRC_T0:  w_x = r_t0;
      default: w_x = r_t1;
    endcase
    case (w_uc.srcy)
      SRC_A:   w_y = r_a;
      SRC_B:   w_y = r_b;
      SRC_T0:  w_y = r_t0;
      default: w_y = r_t1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_ill ? ST_DONE : ST_EXEC;
      ST_EXEC: if (w_uc.last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_EXEC) || (r_state == ST_DONE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= 3'd0;
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_t0     <= '0;
      r_t1     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      // an illegal op skips EXEC entirely and reports a cleared result
      if (w_ill) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end else begin
        r_op   <= op;
        r_a    <= a;
        r_b    <= b;
        r_step <= 3'd0;
        r_err  <= 1'b0;
      end
    end else if (r_state == ST_EXEC) begin
      r_step <= r_step + 3'd1;
      case (w_uc.dst)
        DST_T0:  r_t0     <= w_nor;
        DST_T1:  r_t1     <= w_nor;
        default: r_result <= w_nor;
      endcase
    end
  end

  assign err    = r_err;
  assign result = r_result;

`ifdef NOR_SEQ_CYCLE_COUNT_EN
  logic [2:0] r_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= 3'd0;
    end else if (w_accept && w_ill) begin
      r_cycles <= 3'd0;
    end else if ((r_state == ST_EXEC) && w_uc.last) begin
      r_cycles <= r_step + 3'd1;
    end
  end

  assign cycles = r_cycles;
`else
  // cycle reporting is compiled out in this build
`endif

endmodule

`default_nettype wire

// File: doc/nor_seq_alu.md
Name: nor_seq_alu

Overview:
- Multi-cycle logic unit that builds NOR, OR, NOT, AND, NAND, XOR and XNOR from one shared nor_32bit instance.
- It applies the instance once per clock under microcode control, storing intermediates in two temp registers.
- Sits beside the combinational ALU as a gate-count-minimal logic path. It is driven by a start/done handshake from the datapath controller.

Parameters:
- WIDTH, 32, operand/result width; must match nor_32bit (only 32 supported).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  operation code, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- busy  output  1  high in EXEC and DONE states
- done  output  1  one-cycle completion pulse
- err  output  1  illegal op flag, valid while done=1
- result  output  WIDTH  final value; holds until the next accepted start completes

Behaviour:
- Clocking and reset: one clock domain (clk). rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, err=0, result=0, step=0, temp regs T0/T1=0, latched operands=0.
- Opcodes and step count N:
  - 000 NOR, N=1
  - 001 OR, N=2
  - 010 NOT a, N=1
  - 011 AND, N=3
  - 100 NAND, N=4
  - 101 XOR, N=5
  - 110 XNOR, N=4
  - 111 illegal
- Microcode: each step selects the two NOR inputs from {A, B, T0, T1} and a destination from {T0, T1, result}. The final step always writes result.
  - NOR: result=NOR(A,B)
  - OR: T0=NOR(A,B); result=NOR(T0,T0)
  - NOT: result=NOR(A,A)
  - AND: T0=NOR(A,A); T1=NOR(B,B); result=NOR(T0,T1)
  - NAND: AND's three steps with the third writing T0; then result=NOR(T0,T0)
  - XNOR: T0=NOR(A,B); T1=NOR(A,T0); T0=NOR(B,T0); result=NOR(T1,T0)
  - XOR: XNOR's four steps with the fourth writing T0; then result=NOR(T0,T0)
- FSM IDLE/EXEC/DONE:
  - IDLE, start=1, legal op: latch a/b/op, step=0, go to EXEC.
  - IDLE, start=1, op=111: go to DONE with err=1 and result cleared to 0.
  - EXEC: one microstep per clock, step increments. The step with index N-1 writes result and moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0; done high in the cycle after edge N, i.e. N clocks after start is sampled. Illegal op: done 1 clock after start.
- Back-to-back: a new start is accepted no earlier than the IDLE cycle that follows DONE. Throughput is one op per N+2 cycles.
- start while busy: ignored, not queued. a/b/op may change freely during EXEC because they were latched.
- err: cleared on every accepted start; set only for op=111.
- Reset mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- Macro NOR_SEQ_CYCLE_COUNT_EN.
- Defined: adds output cycles[2:0], equal to the number of EXEC cycles used by the last completed op. It is 0 for illegal ops, reset to 0, and updated at the same edge as done rises.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package nor_seq_pkg holds:
  - opcode localparams OP_NOR..OP_ILL
  - state encodings
  - source-select codes SRC_A/SRC_B/SRC_T0/SRC_T1 and destination codes DST_T0/DST_T1/DST_RES
  - step-count constants per op
- Sub-module nor_seq_ucode: combinational ROM mapping (op, step) to (srcX, srcY, dst, last).
- Top module: instantiates nor_seq_ucode and the existing nor_32bit unchanged; holds FSM, registers and muxes.

Test Plan:
- Operands for all ops: a=32'h9000000A, b=32'h1000001E.
  - op=000 -> done 1 clk after start, result=32'h6FFFFFE1
  - op=001 -> done after 2 clks, result=32'h9000001E
  - op=011 -> done after 3 clks, result=32'h1000000A
  - op=100 -> done after 4 clks, result=32'hEFFFFFF5
- Same operands, op=101 -> done after 5 clks, result=32'h80000014. op=110 -> done after 4 clks, result=32'h7FFFFFEB.
- op=111 -> done and err both high 1 clk after start; result=0. The next legal op clears err.
- Busy handling: raise start again and toggle a/b during EXEC of an XOR -> second start ignored, result is still XOR of the originally latched operands, exactly one done pulse.
- Reset: assert rst_n low at step 2 of an XOR -> busy/done/result go to 0 asynchronously. After release, a NOR op completes normally.
- With NOR_SEQ_CYCLE_COUNT_EN defined: XOR -> cycles=5; following op=111 -> cycles=0.
